// File: rtl/rgb_to_yuv_encoder_pkg.sv
// Shared definitions for the RGB-to-YUV encoder: FSM states, plane base addresses,
// colour-space coefficients and the step boundaries of the 16-cycle group schedule.
package rgb_to_yuv_encoder_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CALC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } enc_state_type;

  localparam logic [17:0] U_BASE_ADDRESS   = 18'd38400;
  localparam logic [17:0] V_BASE_ADDRESS   = 18'd57600;
  localparam logic [17:0] RGB_BASE_ADDRESS = 18'd146944;

  localparam logic signed [31:0] C_YR = 32'sd16843;
  localparam logic signed [31:0] C_YG = 32'sd33030;
  localparam logic signed [31:0] C_YB = 32'sd6423;
  localparam logic signed [31:0] C_UR = -32'sd9699;
  localparam logic signed [31:0] C_UG = -32'sd19071;
  localparam logic signed [31:0] C_UB = 32'sd28770;
  localparam logic signed [31:0] C_VR = 32'sd28770;
  localparam logic signed [31:0] C_VG = -32'sd24117;
  localparam logic signed [31:0] C_VB = -32'sd4653;

  // Rounding half plus the +16 luma / +128 chroma offsets, pre-scaled to the shift.
  localparam logic signed [31:0] Y_OFFSET  = 32'sd1081344;
  localparam logic signed [31:0] UV_OFFSET = 32'sd16842752;
  localparam logic signed [31:0] U8_MAX    = 32'sd255;

  localparam logic [3:0] STEP_CALC  = 4'd6;
  localparam logic [3:0] STEP_WRITE = 4'd11;

  function automatic enc_state_type phase_of(input logic [3:0] step);
    enc_state_type ph;
    if (step >= STEP_WRITE) ph = S_WRITE;
    else if (step >= STEP_CALC) ph = S_CALC;
    else ph = S_READ;
    return ph;
  endfunction

endpackage

// File: rtl/rgb_to_yuv_encoder_clip.sv
// clip_u8: arithmetic right shift by 16 or 17, then saturate to an unsigned byte.
module clip_u8
  import rgb_to_yuv_encoder_pkg::*;
(
  input  logic signed [31:0] value_i,
  input  logic               shift17_i,
  output logic [7:0]         clipped_o
);

  logic signed [31:0] shifted;

  // Scale down and saturate.
  always_comb begin
    if (shift17_i) shifted = value_i >>> 5'd17;
    else shifted = value_i >>> 5'd16;
    if (shifted < 32'sd0) clipped_o = 8'h00;
    else if (shifted > U8_MAX) clipped_o = 8'hFF;
    else clipped_o = shifted[7:0];
  end

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// RGB-to-YUV encoder: reads interleaved RGB groups of 4 pixels from SRAM, converts them
// with three shared multipliers and writes Y, horizontally averaged U and V planes back.
module rgb_to_yuv_encoder
  import rgb_to_yuv_encoder_pkg::*;
#(
  parameter int NUM_GROUPS = 19200
) (
  input  logic        CLOCK_50_I,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        done
);

  localparam logic [17:0] LAST_GROUP = 18'(NUM_GROUPS - 1);

  enc_state_type state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [17:0] group_q, group_d;
  logic [17:0] rgb_addr_q, rgb_addr_d;
  logic [17:0] sram_address_q, sram_address_d;
  logic [15:0] sram_write_data_q, sram_write_data_d;
  logic        sram_we_n_q, sram_we_n_d;
  logic        done_q, done_d;
  logic [7:0]  r_q [4], r_d [4], g_q [4], g_d [4], b_q [4], b_d [4];
  logic [7:0]  y_q [4], y_d [4], u_q [2], u_d [2], v_q [2], v_d [2];
  logic signed [31:0] acc_y_q, acc_y_d, acc_u_q, acc_u_d, acc_v_q, acc_v_d;

  logic [8:0]  rs [2], gs [2], bs [2];
  logic signed [31:0] coef_a, coef_b, coef_c, offset, mac_sum;
  logic [8:0]  x_a, x_b, x_c;
  logic [7:0]  clip_y, clip_u, clip_v;
  logic [1:0]  yi;
  logic        pi;

  assign rs[0] = {1'b0, r_q[0]} + {1'b0, r_q[1]};
  assign gs[0] = {1'b0, g_q[0]} + {1'b0, g_q[1]};
  assign bs[0] = {1'b0, b_q[0]} + {1'b0, b_q[1]};
  assign rs[1] = {1'b0, r_q[2]} + {1'b0, r_q[3]};
  assign gs[1] = {1'b0, g_q[2]} + {1'b0, g_q[3]};
  assign bs[1] = {1'b0, b_q[2]} + {1'b0, b_q[3]};

  // Luma steps 4,5,8,9 map to pixels 0..3; chroma steps 6/7 and 10/11 map to pairs 0/1.
  assign yi = {step_q[3], step_q[0]};
  assign pi = step_q[3];

  // Steer the three shared multipliers according to the step within the group.
  always_comb begin
    coef_a = 32'sd0; coef_b = 32'sd0; coef_c = 32'sd0; offset = 32'sd0;
    x_a = 9'd0; x_b = 9'd0; x_c = 9'd0;
    case (step_q)
      4'd4, 4'd5, 4'd8, 4'd9: begin
        coef_a = C_YR; coef_b = C_YG; coef_c = C_YB; offset = Y_OFFSET;
        x_a = {1'b0, r_q[yi]}; x_b = {1'b0, g_q[yi]}; x_c = {1'b0, b_q[yi]};
      end
      4'd6, 4'd10: begin
        coef_a = C_UR; coef_b = C_UG; coef_c = C_UB; offset = UV_OFFSET;
        x_a = rs[pi]; x_b = gs[pi]; x_c = bs[pi];
      end
      4'd7, 4'd11: begin
        coef_a = C_VR; coef_b = C_VG; coef_c = C_VB; offset = UV_OFFSET;
        x_a = rs[pi]; x_b = gs[pi]; x_c = bs[pi];
      end
      default: begin
        offset = 32'sd0;
      end
    endcase
  end

  assign mac_sum = coef_a * $signed({23'd0, x_a}) + coef_b * $signed({23'd0, x_b})
                 + coef_c * $signed({23'd0, x_c}) + offset;

  clip_u8 u_clip_y (.value_i(acc_y_q), .shift17_i(1'b0), .clipped_o(clip_y));
  clip_u8 u_clip_u (.value_i(acc_u_q), .shift17_i(1'b1), .clipped_o(clip_u));
  clip_u8 u_clip_v (.value_i(acc_v_q), .shift17_i(1'b1), .clipped_o(clip_v));

  // Next-state logic: reads at steps 0-4 (and 15 for the next group), captures at 2-7,
  // multiplies at 4-11, writes issued at steps 11-14.
  always_comb begin
    state_d = state_q; step_d = step_q; group_d = group_q; rgb_addr_d = rgb_addr_q;
    sram_address_d = sram_address_q; sram_write_data_d = sram_write_data_q;
    sram_we_n_d = 1'b1; done_d = done_q;
    r_d = r_q; g_d = g_q; b_d = b_q; y_d = y_q; u_d = u_q; v_d = v_q;
    acc_y_d = acc_y_q; acc_u_d = acc_u_q; acc_v_d = acc_v_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (enable) begin
          state_d = S_READ; step_d = 4'd0; group_d = 18'd0;
          sram_address_d = RGB_BASE_ADDRESS;
          rgb_addr_d = RGB_BASE_ADDRESS + 18'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ, S_CALC, S_WRITE: begin
        step_d = step_q + 4'd1;
        state_d = phase_of(step_q + 4'd1);
        case (step_q)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
            sram_address_d = rgb_addr_q; rgb_addr_d = rgb_addr_q + 18'd1;
          end
          4'd11: begin
            sram_address_d = {group_q[16:0], 1'b0};
            sram_write_data_d = {y_q[0], y_q[1]}; sram_we_n_d = 1'b0;
          end
          4'd12: begin
            sram_address_d = {group_q[16:0], 1'b1};
            sram_write_data_d = {y_q[2], y_q[3]}; sram_we_n_d = 1'b0;
          end
          4'd13: begin
            sram_address_d = U_BASE_ADDRESS + group_q;
            sram_write_data_d = {u_q[0], u_q[1]}; sram_we_n_d = 1'b0;
          end
          4'd14: begin
            sram_address_d = V_BASE_ADDRESS + group_q;
            sram_write_data_d = {v_q[0], v_q[1]}; sram_we_n_d = 1'b0;
          end
          4'd15: begin
            group_d = group_q + 18'd1;
            if (group_q == LAST_GROUP) begin
              state_d = S_DONE; done_d = 1'b1; step_d = 4'd0;
            end else begin
              sram_address_d = rgb_addr_q; rgb_addr_d = rgb_addr_q + 18'd1;
            end
          end
          default: begin
            sram_we_n_d = 1'b1;
          end
        endcase
        case (step_q)
          4'd2: begin r_d[0] = SRAM_read_data[15:8]; g_d[0] = SRAM_read_data[7:0]; end
          4'd3: begin b_d[0] = SRAM_read_data[15:8]; r_d[1] = SRAM_read_data[7:0]; end
          4'd4: begin g_d[1] = SRAM_read_data[15:8]; b_d[1] = SRAM_read_data[7:0]; end
          4'd5: begin r_d[2] = SRAM_read_data[15:8]; g_d[2] = SRAM_read_data[7:0]; end
          4'd6: begin b_d[2] = SRAM_read_data[15:8]; r_d[3] = SRAM_read_data[7:0]; end
          4'd7: begin g_d[3] = SRAM_read_data[15:8]; b_d[3] = SRAM_read_data[7:0]; end
          default: begin r_d = r_q; end
        endcase
        case (step_q)
          4'd4:  acc_y_d = mac_sum;
          4'd5:  begin y_d[0] = clip_y; acc_y_d = mac_sum; end
          4'd6:  begin y_d[1] = clip_y; acc_u_d = mac_sum; end
          4'd7:  begin u_d[0] = clip_u; acc_v_d = mac_sum; end
          4'd8:  begin v_d[0] = clip_v; acc_y_d = mac_sum; end
          4'd9:  begin y_d[2] = clip_y; acc_y_d = mac_sum; end
          4'd10: begin y_d[3] = clip_y; acc_u_d = mac_sum; end
          4'd11: begin u_d[1] = clip_u; acc_v_d = mac_sum; end
          4'd12: v_d[1] = clip_v;
          default: begin acc_y_d = acc_y_q; end
        endcase
      end
      S_DONE: begin
        if (enable) begin
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE; done_d = 1'b0; step_d = 4'd0;
          group_d = 18'd0; rgb_addr_d = 18'd0;
        end
      end
      default: begin
        state_d = S_IDLE; done_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      state_q <= S_IDLE; step_q <= 4'd0; group_q <= 18'd0; rgb_addr_q <= 18'd0;
      sram_address_q <= 18'd0; sram_write_data_q <= 16'd0; sram_we_n_q <= 1'b1;
      done_q <= 1'b0;
      r_q <= '{default: 8'h00}; g_q <= '{default: 8'h00}; b_q <= '{default: 8'h00};
      y_q <= '{default: 8'h00}; u_q <= '{default: 8'h00}; v_q <= '{default: 8'h00};
      acc_y_q <= 32'sd0; acc_u_q <= 32'sd0; acc_v_q <= 32'sd0;
    end else begin
      state_q <= state_d; step_q <= step_d; group_q <= group_d; rgb_addr_q <= rgb_addr_d;
      sram_address_q <= sram_address_d; sram_write_data_q <= sram_write_data_d;
      sram_we_n_q <= sram_we_n_d; done_q <= done_d;
      r_q <= r_d; g_q <= g_d; b_q <= b_d; y_q <= y_d; u_q <= u_d; v_q <= v_d;
      acc_y_q <= acc_y_d; acc_u_q <= acc_u_d; acc_v_q <= acc_v_d;
    end
  end

  assign SRAM_address    = sram_address_q;
  assign SRAM_write_data = sram_write_data_q;
  assign SRAM_we_n       = sram_we_n_q;
  assign done            = done_q;

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Bench for rgb_to_yuv_encoder on a reduced image: SRAM model with 3-edge read latency,
// arithmetic reference model, directed colour images, random images, reset and done-hold.
module tb_rgb_to_yuv_encoder;

  localparam int NG       = 24;
  localparam int NPIX     = 4 * NG;
  localparam int RGB_BASE = 146944;
  localparam int U_BASE   = 38400;
  localparam int V_BASE   = 57600;
  localparam int BUDGET   = 16 * NG + 32;

  logic        clk = 1'b0;
  logic        reset, enable, clr_log;
  logic [15:0] SRAM_read_data, SRAM_write_data;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n, done;

  logic [15:0] mem [0:262143];
  logic [15:0] img [6*NG];
  logic [15:0] rd_p1, rd_p2;
  logic [7:0]  pr [NPIX], pg [NPIX], pb [NPIX];
  int          y_wc [2*NG], u_wc [NG], v_wc [NG];
  int          bad_wr, wr_total, wa;
  int          checks = 0, failures = 0;

  rgb_to_yuv_encoder #(.NUM_GROUPS(NG)) dut (
    .CLOCK_50_I(clk), .reset(reset), .enable(enable),
    .SRAM_read_data(SRAM_read_data), .SRAM_address(SRAM_address),
    .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n), .done(done)
  );

  initial forever #10 clk = ~clk;

  assign SRAM_read_data = rd_p2;
  always_comb wa = int'(SRAM_address);

  // SRAM model: reads of the source region come from img; writes land in mem and are logged.
  always @(posedge clk) begin
    rd_p1 <= (wa >= RGB_BASE && wa < RGB_BASE + 6 * NG) ? img[wa - RGB_BASE] : mem[SRAM_address];
    rd_p2 <= rd_p1;
    if (!SRAM_we_n) mem[SRAM_address] <= SRAM_write_data;
    if (clr_log) begin
      for (int i = 0; i < 2 * NG; i++) y_wc[i] <= 0;
      for (int i = 0; i < NG; i++) begin u_wc[i] <= 0; v_wc[i] <= 0; end
      bad_wr <= 0; wr_total <= 0;
    end else if (!SRAM_we_n) begin
      wr_total <= wr_total + 1;
      if (wa < 2 * NG) y_wc[wa] <= y_wc[wa] + 1;
      else if (wa >= U_BASE && wa < U_BASE + NG) u_wc[wa - U_BASE] <= u_wc[wa - U_BASE] + 1;
      else if (wa >= V_BASE && wa < V_BASE + NG) v_wc[wa - V_BASE] <= v_wc[wa - V_BASE] + 1;
      else bad_wr <= bad_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clip8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int exp_y(input int p);
    return clip8((16843 * int'(pr[p]) + 33030 * int'(pg[p]) + 6423 * int'(pb[p])
                  + 32768 + (16 << 16)) >>> 16);
  endfunction

  function automatic int exp_uv(input int q, input bit is_v);
    int rs, gs, bs;
    rs = int'(pr[2*q]) + int'(pr[2*q+1]);
    gs = int'(pg[2*q]) + int'(pg[2*q+1]);
    bs = int'(pb[2*q]) + int'(pb[2*q+1]);
    if (is_v) return clip8((28770 * rs - 24117 * gs - 4653 * bs + (128 << 17) + 65536) >>> 17);
    return clip8((-9699 * rs - 19071 * gs + 28770 * bs + (128 << 17) + 65536) >>> 17);
  endfunction

  task automatic set_px(input int p, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pr[p] = r; pg[p] = g; pb[p] = b;
  endtask

  // mode 0 white, 1 black, 2 red/blue pattern in groups 0-1 over random, else random.
  task automatic load_image(input int mode);
    for (int p = 0; p < NPIX; p++) begin
      if (mode == 0) set_px(p, 8'hFF, 8'hFF, 8'hFF);
      else if (mode == 1) set_px(p, 8'h00, 8'h00, 8'h00);
      else set_px(p, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    if (mode == 2) begin
      set_px(0, 8'hFF, 8'h00, 8'h00); set_px(1, 8'h00, 8'h00, 8'hFF);
      set_px(2, 8'hFF, 8'h00, 8'h00); set_px(3, 8'h00, 8'h00, 8'hFF);
      set_px(4, 8'hFF, 8'h00, 8'h00); set_px(5, 8'hFF, 8'h00, 8'h00);
      set_px(6, 8'h00, 8'h00, 8'hFF); set_px(7, 8'h00, 8'h00, 8'hFF);
    end
    for (int q = 0; q < NPIX / 2; q++) begin
      img[3*q]   = {pr[2*q], pg[2*q]};
      img[3*q+1] = {pb[2*q], pr[2*q+1]};
      img[3*q+2] = {pg[2*q+1], pb[2*q+1]};
    end
  endtask

  task automatic run_conv(input bit toggle);
    int cyc;
    bit seen;
    clr_log = 1'b1; @(negedge clk); clr_log = 1'b0;
    enable = 1'b1; cyc = 0; seen = 1'b0;
    while (!seen && cyc < BUDGET) begin
      @(negedge clk); cyc++;
      if (toggle && cyc == 40) enable = 1'b0;
      if (toggle && cyc == 43) enable = 1'b1;
      if (done) seen = 1'b1;
    end
    check("done_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic verify_model(input string tag);
    for (int w = 0; w < 2 * NG; w++) begin
      check($sformatf("%s_Y%0d", tag, w), 32'(mem[w]), 32'((exp_y(2*w) << 8) | exp_y(2*w+1)));
      check($sformatf("%s_Ywrites%0d", tag, w), 32'(y_wc[w]), 32'd1);
    end
    for (int g = 0; g < NG; g++) begin
      check($sformatf("%s_U%0d", tag, g), 32'(mem[U_BASE+g]),
            32'((exp_uv(2*g, 1'b0) << 8) | exp_uv(2*g+1, 1'b0)));
      check($sformatf("%s_V%0d", tag, g), 32'(mem[V_BASE+g]),
            32'((exp_uv(2*g, 1'b1) << 8) | exp_uv(2*g+1, 1'b1)));
      check($sformatf("%s_UVwrites%0d", tag, g), 32'(u_wc[g] + 2 * v_wc[g]), 32'd3);
    end
    check({tag, "_stray_writes"}, 32'(bad_wr), 32'd0);
  endtask

  task automatic verify_const(input string tag, input logic [15:0] yw, input logic [15:0] cw);
    for (int w = 0; w < 2 * NG; w++) check($sformatf("%s_Y%0d", tag, w), 32'(mem[w]), 32'(yw));
    for (int g = 0; g < NG; g++) begin
      check($sformatf("%s_U%0d", tag, g), 32'(mem[U_BASE+g]), 32'(cw));
      check($sformatf("%s_V%0d", tag, g), 32'(mem[V_BASE+g]), 32'(cw));
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic go_idle();
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clr_log = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we_n", 32'(SRAM_we_n), 32'd1);
    check("rst_addr", 32'(SRAM_address), 32'd0);
    check("rst_wdata", 32'(SRAM_write_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    load_image(0); run_conv(1'b0); verify_const("white", 16'hEBEB, 16'h8080); go_idle();
    load_image(1); run_conv(1'b0); verify_const("black", 16'h1010, 16'h8080); go_idle();

    load_image(2); run_conv(1'b0);
    check("rb_Y0", 32'(mem[0]), 32'h5229);
    check("rb_Y1", 32'(mem[1]), 32'h5229);
    check("rb_U0", 32'(mem[U_BASE]), 32'hA5A5);
    check("rb_V0", 32'(mem[V_BASE]), 32'hAFAF);
    check("rb_Y2", 32'(mem[2]), 32'h5252);
    check("rb_Y3", 32'(mem[3]), 32'h2929);
    check("rb_U1", 32'(mem[U_BASE+1]), 32'h5AF0);
    check("rb_V1", 32'(mem[V_BASE+1]), 32'hF06E);
    verify_model("rb");
    go_idle();

    // Random image with enable glitching while busy; then enable held high after done.
    load_image(3); run_conv(1'b1); verify_model("rand");
    clr_log = 1'b1; @(negedge clk); clr_log = 1'b0;
    repeat (40) @(negedge clk);
    check("hold_no_writes", 32'(wr_total), 32'd0);
    check("hold_done", 32'(done), 32'd1);
    enable = 1'b0; @(negedge clk);
    check("release_done", 32'(done), 32'd0);
    repeat (10) @(negedge clk);
    check("idle_no_writes", 32'(wr_total), 32'd0);
    check("idle_we_n", 32'(SRAM_we_n), 32'd1);

    // Reset in the middle of a group, then a clean rerun.
    load_image(3);
    enable = 1'b1;
    repeat (16 * 3 + 12) @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    check("midrst_we_n", 32'(SRAM_we_n), 32'd1);
    check("midrst_addr", 32'(SRAM_address), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_idle_we_n", 32'(SRAM_we_n), 32'd1);
    load_image(3); run_conv(1'b0); verify_model("rerun"); go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
